// File: rtl/mcp3008_responder.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_responder
// Purpose  : Device-side model of the MCP3008 10-bit SPI ADC. Oversamples the
//            host's dclk/cs_n/din pins on the fast system clock, decodes the
//            start bit + SGL/DIFF + D2..D0 command, asks a value provider for
//            a 10-bit result and shifts out the null bit followed by B9..B0.
//            SPI modes 0,0 and 1,1 are both accepted.
// Ports    : clk, rst_n          system clock, asynchronous active-low reset
//            dclk, cs_n, din     host SPI pins (asynchronous to clk)
//            dout, dout_oe       result bit and pad output enable
//            ch_sel, sgl_diff    decoded channel / mode, held until next cmd
//            sample_req          one-clk pulse when ch_sel/sgl_diff update
//            sample_data         provider result, latched 1 clk after the req
//            busy                start bit seen, cs_n not yet released
//            xfer_done           one-clk pulse on the edge that drives B0
//            frame_err           one-clk pulse on cs_n release mid-command/data
// Macro    : MCP3008_RESPONDER_LSB_TAIL_EN - after B0, continue with B1..B9
//            LSB first (datasheet continued-clock behaviour); otherwise the
//            tail shifts zeros.
// Revision : 1.0 - initial release
// ============================================================================
module mcp3008_responder #(
    parameter int   SYNC_STAGES = 2,     // 2..4 flops per pin synchronizer
    parameter logic IDLE_DOUT   = 1'b0   // dout level while dout_oe = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dclk,
    input  logic       cs_n,
    input  logic       din,
    output logic       dout,
    output logic       dout_oe,
    output logic [2:0] ch_sel,
    output logic       sgl_diff,
    output logic       sample_req,
    input  logic [9:0] sample_data,
    output logic       busy,
    output logic       xfer_done,
    output logic       frame_err
);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_WAIT_START = 3'd1;
    localparam logic [2:0] c_CMD        = 3'd2;
    localparam logic [2:0] c_SAMPLE     = 3'd3;
    localparam logic [2:0] c_DATA       = 3'd4;
    localparam logic [2:0] c_TAIL       = 3'd5;

    // ------------------------------------------------------------------
    // Pin synchronizers. din shares the dclk stage depth so the bit seen
    // alongside a detected dclk rise is the bit the host presented.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_dclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_dclk_prev;
    logic                   r_cs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dclk_sync <= '0;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_dclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_dclk_sync <= {r_dclk_sync[SYNC_STAGES-2:0], dclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din};
            r_dclk_prev <= r_dclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_dclk_rise;
    logic w_dclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_din_s;

    assign w_dclk_rise = r_dclk_sync[SYNC_STAGES-1] & ~r_dclk_prev;
    assign w_dclk_fall = ~r_dclk_sync[SYNC_STAGES-1] & r_dclk_prev;
    assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
    assign w_din_s     = r_din_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    logic [2:0] r_state, w_state;
    logic [3:0] r_cnt, w_cnt;       // command bits / ignored falls / data index
    logic [2:0] r_cmd, w_cmd;       // SGL/DIFF, D2, D1 collected so far
    logic [9:0] r_data;
    logic       r_dout, w_dout;
    logic       r_dout_oe, w_dout_oe;
    logic [2:0] r_ch_sel, w_ch_sel;
    logic       r_sgl, w_sgl;
    logic       r_sample_req, w_sample_req;
    logic       r_busy, w_busy;
    logic       r_xfer_done, w_xfer_done;
    logic       r_frame_err, w_frame_err;
    logic [3:0] w_idx;

    assign w_idx = 4'd9 - r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_cmd        <= 3'd0;
            r_dout       <= IDLE_DOUT;
            r_dout_oe    <= 1'b0;
            r_ch_sel     <= 3'd0;
            r_sgl        <= 1'b0;
            r_sample_req <= 1'b0;
            r_busy       <= 1'b0;
            r_xfer_done  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_cmd        <= w_cmd;
            r_dout       <= w_dout;
            r_dout_oe    <= w_dout_oe;
            r_ch_sel     <= w_ch_sel;
            r_sgl        <= w_sgl;
            r_sample_req <= w_sample_req;
            r_busy       <= w_busy;
            r_xfer_done  <= w_xfer_done;
            r_frame_err  <= w_frame_err;
        end
    end

    // The provider answers during the clk that sample_req is high; take the
    // value at the end of that clk so every frame uses a fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 10'd0;
        end else if (r_sample_req) begin
            r_data <= sample_data;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_cmd        = r_cmd;
        w_dout       = r_dout;
        w_dout_oe    = r_dout_oe;
        w_ch_sel     = r_ch_sel;
        w_sgl        = r_sgl;
        w_sample_req = 1'b0;
        w_busy       = r_busy;
        w_xfer_done  = 1'b0;
        w_frame_err  = 1'b0;

        // cs_n release has priority over any dclk edge seen in the same clk.
        if ((r_state != c_IDLE) && w_cs_rise) begin
            w_state     = c_IDLE;
            w_dout      = IDLE_DOUT;
            w_dout_oe   = 1'b0;
            w_busy      = 1'b0;
            w_frame_err = (r_state == c_CMD) || (r_state == c_SAMPLE) ||
                          (r_state == c_DATA);
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_cs_fall) begin
                        w_state = c_WAIT_START;
                    end
                end
                c_WAIT_START: begin
                    // Leading zeros before the start bit are legal.
                    if (w_dclk_rise && w_din_s) begin
                        w_state = c_CMD;
                        w_cnt   = 4'd0;
                        w_busy  = 1'b1;
                    end
                end
                c_CMD: begin
                    if (w_dclk_rise) begin
                        w_cmd = {r_cmd[1:0], w_din_s};
                        if (r_cnt == 4'd3) begin
                            // This rise carries D0: the command is complete.
                            w_sgl        = r_cmd[2];
                            w_ch_sel     = {r_cmd[1:0], w_din_s};
                            w_sample_req = 1'b1;
                            w_state      = c_SAMPLE;
                            w_cnt        = 4'd0;
                        end else begin
                            w_cnt = r_cnt + 4'd1;
                        end
                    end
                end
                c_SAMPLE: begin
                    // First fall (same clock as D0) is skipped; the second
                    // one drives the null bit.
                    if (w_dclk_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_cnt = 4'd1;
                        end else begin
                            w_dout    = 1'b0;
                            w_dout_oe = 1'b1;
                            w_state   = c_DATA;
                            w_cnt     = 4'd0;
                        end
                    end
                end
                c_DATA: begin
                    if (w_dclk_fall) begin
                        w_dout = r_data[w_idx];
                        if (r_cnt == 4'd9) begin
                            w_xfer_done = 1'b1;
                            w_state     = c_TAIL;
                            w_cnt       = 4'd1;
                        end else begin
                            w_cnt = r_cnt + 4'd1;
                        end
                    end
                end
                c_TAIL: begin
                    if (w_dclk_fall) begin
`ifdef MCP3008_RESPONDER_LSB_TAIL_EN
                        // r_cnt walks B1..B9 then parks at 10 (zeros).
                        if (r_cnt != 4'd10) begin
                            w_dout = r_data[r_cnt];
                            w_cnt  = r_cnt + 4'd1;
                        end else begin
                            w_dout = 1'b0;
                        end
`else
                        w_dout = 1'b0;
`endif
                    end
                end
                default: begin
                    w_state   = c_IDLE;
                    w_dout    = IDLE_DOUT;
                    w_dout_oe = 1'b0;
                    w_busy    = 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_oe    = r_dout_oe;
    assign ch_sel     = r_ch_sel;
    assign sgl_diff   = r_sgl;
    assign sample_req = r_sample_req;
    assign busy       = r_busy;
    assign xfer_done  = r_xfer_done;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: doc/mcp3008_responder.md
Name: mcp3008_responder

Overview:
- Device-side model of the MCP3008 SPI ADC, synthesizable, runs on a single fast system clock.
- Watches the host's dclk/cs_n/din pins through synchronizers and decodes the 5-bit command (start, SGL/DIFF, D2..D0).
- Requests a 10-bit result from a value provider and shifts out the null bit plus B9..B0 on dout.
- Used as a loopback ADC stand-in on the board FPGA and as the bus-functional responder in host-interface testbenches.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchronizer on dclk, cs_n and din (allowed range 2..4).
- IDLE_DOUT, 1'b0, value driven on dout whenever dout_oe=0.

Ports:
- clk  in  1  system clock; must be at least 8x the dclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- dclk  in  1  SPI clock from the host, asynchronous to clk; mode 0,0 and mode 1,1 both accepted.
- cs_n  in  1  active-low chip select from the host, asynchronous.
- din  in  1  command bits from the host, sampled on dclk rising edges.
- dout  out  1  result bits, changed on dclk falling edges.
- dout_oe  out  1  high while the block drives a meaningful dout (drives the pad tristate).
- ch_sel  out  3  decoded D2..D0, held from decode until the next command.
- sgl_diff  out  1  decoded SGL/DIFF bit, held with ch_sel.
- sample_req  out  1  one-clk pulse when ch_sel/sgl_diff become valid.
- sample_data  in  10  result from the value provider; latched exactly 1 clk after sample_req.
- busy  out  1  high from the start bit until cs_n goes high.
- xfer_done  out  1  one-clk pulse on the falling edge that drives B0.
- frame_err  out  1  one-clk pulse when cs_n rises after the start bit but before B0 is driven.

Behaviour:
- Reset values: dout=IDLE_DOUT, dout_oe=0, ch_sel=0, sgl_diff=0, sample_req=0, busy=0, xfer_done=0, frame_err=0. State is IDLE.
- Reset asserted mid-frame returns everything to the reset values immediately. The frame is not resumed; the next cs_n fall starts fresh.
- Edge detection:
  - Each pin is synchronized by SYNC_STAGES flops; an edge is detected by comparing the last two synchronized values.
  - din is taken from the same synchronizer stage as dclk, so the two stay aligned.
  - Internal edge events lag the pins by SYNC_STAGES+1 clk.
- FSM (clock numbers count dclk cycles, clock 1 = the start bit):
  - IDLE: cs_n fall -> WAIT_START.
  - WAIT_START: each dclk rise samples din. din=0 is ignored (leading zeros are legal). din=1 -> CMD, bit counter=0, busy=1.
  - CMD: four dclk rises shift in SGL/DIFF, D2, D1, D0. On the D0 rise (clock 5): update ch_sel/sgl_diff, pulse sample_req, latch sample_data into the shift register on the next clk -> SAMPLE.
  - SAMPLE: the falling edge of clock 5 is ignored. On the falling edge of clock 6: dout=0 (null bit), dout_oe=1 -> DATA.
  - DATA: falling edges of clocks 7..16 drive B9..B0, MSB first. The clock-16 edge also pulses xfer_done -> TAIL.
  - TAIL: behaviour is set by LSB_TAIL_EN (see Optional Feature).
- cs_n rise in any state except IDLE:
  - Go to IDLE; dout_oe=0, dout=IDLE_DOUT, busy=0, all within SYNC_STAGES+2 clk of the pin edge.
  - Pulse frame_err if the state was CMD, SAMPLE or DATA.
  - A cs_n rise in WAIT_START gives no error.
- A dclk edge detected in the same clk as the cs_n rise is discarded; cs_n wins.
- dclk rising edges in SAMPLE, DATA and TAIL do not change state.
- A new frame needs cs_n high for at least one clk after synchronization. The previous sample_data is never reused.
- ch_sel and sgl_diff keep their values across frames; only reset clears them.

Optional Feature:
- Macro: MCP3008_RESPONDER_LSB_TAIL_EN.
- Defined: TAIL drives B1..B9 (LSB first) on falling edges 17..25, then 0 on every later falling edge until cs_n rises. This is the datasheet's continued-clock behaviour.
- Undefined: TAIL drives 0 on every falling edge until cs_n rises. The LSB-first logic is not synthesized.

Test Plan:
- Mode 0,0, clk=16x dclk, din stream 1,1,0,1,0 (single-ended CH2), sample_data=10'h2A5 -> ch_sel=2, sgl_diff=1, one sample_req pulse; dout samples on rises 7..17 = 0,1,0,1,0,1,0,0,1,0,1; one xfer_done pulse; frame_err stays 0.
- Back-to-back frames with commands 1_0_000 then 1_0_010 (pseudo-diff CH0 then CH2), provider returning 10'h3FF then 10'h001 -> ch_sel 0 then 2, sgl_diff=0 both times; B9..B0 = all ones, then 0000000001.
- Three leading zeros before the start bit, command 1,1,1,1,1 -> still decoded as CH7 single-ended; the null bit appears on the 9th falling edge after cs_n fall.
- cs_n rise after 8 dclk (in DATA) -> frame_err pulse, dout_oe=0 within SYNC_STAGES+2 clk, busy=0; the next frame decodes correctly.
- rst_n pulsed low during DATA -> all outputs return to reset values asynchronously; the following frame with sample_data=10'h155 completes correctly.
- 26 dclk with sample_data=10'h201 -> with the macro, tail rises 18..26 show 0,0,0,0,0,0,0,0,1; without it, all zeros.
